// File: rtl/cheat_loader_if.sv
// Bundles the byte stream that carries cheat records and the Wishbone
// pipelined write channel of the cheat loader.
// The master view belongs to the loader; the slave view is for whatever
// feeds the stream bytes and answers the bus.
interface cheat_loader_if;
  // byte stream into the loader
  logic         i_byte_valid;
  logic [7:0]   i_byte;
  logic         o_byte_ready;

  // Wishbone pipelined write channel out of the loader
  logic         o_wb_cyc;
  logic         o_wb_stb;
  logic         o_wb_we;
  logic [1:0]   o_wb_addr;
  logic [128:0] o_wb_odata;
  logic         i_wb_ack;
  logic         i_wb_stall;
  logic         i_wb_err;

  modport master (
    input  i_byte_valid, i_byte, i_wb_ack, i_wb_stall, i_wb_err,
    output o_byte_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_odata
  );

  modport slave (
    output i_byte_valid, i_byte, i_wb_ack, i_wb_stall, i_wb_err,
    input  o_byte_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_odata
  );
endinterface

// File: rtl/cheat_loader.sv
// Cheat list loader.
// Collects 5-byte cheat records (flags, addr hi, addr lo, compare, replace)
// from a byte stream and writes each one as a single 129-bit Wishbone word
// to address 1, tagging it with its 1-based slot number. Bus errors, ack
// timeouts, records beyond MAX_CHEATS and truncated records set a sticky
// error flag. The list ends with a load_end pulse, which commits it.
module cheat_loader #(
  parameter int MAX_CHEATS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load_start,
  input  logic                  i_load_end,
  cheat_loader_if.master        bus,
  output logic                  o_cheats_loaded,
  output logic [7:0]            o_cheat_count,
  output logic                  o_error
);

  // The ack timer only has to represent 0..TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    SLOT_LIMIT = 8'(MAX_CHEATS);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    REQ,
    WAIT_ACK,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic           cmpEn_q, cmpEn_d;
  logic [7:0]     addrHi_q, addrHi_d;
  logic [7:0]     addrLo_q, addrLo_d;
  logic [7:0]     cmpVal_q, cmpVal_d;
  logic [128:0]   odata_q, odata_d;
  logic [7:0]     count_q, count_d;
  logic           loaded_q, loaded_d;
  logic           error_q, error_d;
  logic           endPend_q, endPend_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           txnEnd;
  logic [128:0]   recordWord;

  // Assemble the bus word for the record completing with the current byte;
  // the slot is the one after the last successfully written record.
  always_comb begin
    recordWord          = '0;
    recordWord[111:104] = count_q + 8'd1;
    recordWord[96]      = cmpEn_q;
    recordWord[79:64]   = {addrHi_q, addrLo_q};
    recordWord[39:32]   = cmpVal_q;
    recordWord[7:0]     = bus.i_byte;
  end

  // Next-state logic: record collection, the single-beat bus write and the
  // bookkeeping of count, error and committed status.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cmpEn_d   = cmpEn_q;
    addrHi_d  = addrHi_q;
    addrLo_d  = addrLo_q;
    cmpVal_d  = cmpVal_q;
    odata_d   = odata_q;
    count_d   = count_q;
    loaded_d  = loaded_q;
    error_d   = error_q;
    endPend_d = endPend_q;
    timer_d   = timer_q;
    txnEnd    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (i_load_start) begin
          state_d   = COLLECT;
          idx_d     = '0;
          count_d   = '0;
          loaded_d  = 1'b0;
          error_d   = 1'b0;
          endPend_d = 1'b0;
        end
      end

      COLLECT: begin
        if (i_load_start) begin
          // A new start throws away whatever list was in progress.
          idx_d     = '0;
          count_d   = '0;
          loaded_d  = 1'b0;
          error_d   = 1'b0;
          endPend_d = 1'b0;
        end else if (i_load_end) begin
          // Ending the list wins over a byte offered in the same cycle;
          // a half-received record is dropped and flagged.
          state_d  = DONE;
          loaded_d = 1'b1;
          idx_d    = '0;
          if (idx_q != 3'd0) begin
            error_d = 1'b1;
          end
        end else if (bus.i_byte_valid) begin
          case (idx_q)
            3'd0:    cmpEn_d  = bus.i_byte[0];
            3'd1:    addrHi_d = bus.i_byte;
            3'd2:    addrLo_d = bus.i_byte;
            3'd3:    cmpVal_d = bus.i_byte;
            default: ;
          endcase
          if (idx_q == 3'd4) begin
            idx_d = '0;
            if (count_q >= SLOT_LIMIT) begin
              // No slot left: the record is dropped without a bus cycle.
              error_d = 1'b1;
            end else begin
              odata_d = recordWord;
              state_d = REQ;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      REQ: begin
        if (i_load_end) begin
          endPend_d = 1'b1;
        end
        if (bus.i_wb_err) begin
          error_d = 1'b1;
          txnEnd  = 1'b1;
        end else if (!bus.i_wb_stall) begin
          if (bus.i_wb_ack) begin
            count_d = count_q + 8'd1;
            txnEnd  = 1'b1;
          end else begin
            state_d = WAIT_ACK;
            timer_d = '0;
          end
        end
      end

      WAIT_ACK: begin
        if (i_load_end) begin
          endPend_d = 1'b1;
        end
        if (bus.i_wb_err) begin
          error_d = 1'b1;
          txnEnd  = 1'b1;
        end else if (bus.i_wb_ack) begin
          count_d = count_q + 8'd1;
          txnEnd  = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          // A silent slave is handled exactly like a bus error.
          error_d = 1'b1;
          txnEnd  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A finished transaction either resumes collection or, if the list end
    // arrived while the bus was busy, commits the list now.
    if (txnEnd) begin
      if (endPend_q || i_load_end) begin
        state_d   = DONE;
        loaded_d  = 1'b1;
        endPend_d = 1'b0;
      end else begin
        state_d = COLLECT;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cmpEn_q   <= 1'b0;
      addrHi_q  <= '0;
      addrLo_q  <= '0;
      cmpVal_q  <= '0;
      odata_q   <= '0;
      count_q   <= '0;
      loaded_q  <= 1'b0;
      error_q   <= 1'b0;
      endPend_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cmpEn_q   <= cmpEn_d;
      addrHi_q  <= addrHi_d;
      addrLo_q  <= addrLo_d;
      cmpVal_q  <= cmpVal_d;
      odata_q   <= odata_d;
      count_q   <= count_d;
      loaded_q  <= loaded_d;
      error_q   <= error_d;
      endPend_q <= endPend_d;
      timer_q   <= timer_d;
    end
  end

  // Bus and stream controls depend only on the registered state, so a reset
  // or a finished transaction drops cyc on the very next cycle.
  assign bus.o_byte_ready = (state_q == COLLECT);
  assign bus.o_wb_cyc     = (state_q == REQ) || (state_q == WAIT_ACK);
  assign bus.o_wb_stb     = (state_q == REQ);
  assign bus.o_wb_we      = bus.o_wb_cyc;
  assign bus.o_wb_addr    = bus.o_wb_cyc ? 2'h1 : 2'h0;
  assign bus.o_wb_odata   = odata_q;

  assign o_cheats_loaded  = loaded_q;
  assign o_cheat_count    = count_q;
  assign o_error          = error_q;

endmodule

// File: tb/tb_cheat_loader.sv
// Self-checking bench for cheat_loader: directed scenarios followed by
// randomized cheat lists, all compared against a list-level model of count,
// error flag, commit flag and the expected bus word for each record.
module tb_cheat_loader;

  localparam int MAX_CHEATS = 4;
  localparam int TIMEOUT    = 255;

  localparam int RESP_ACK_NOW   = 0;
  localparam int RESP_ACK_LATER = 1;
  localparam int RESP_ERR       = 2;
  localparam int RESP_TIMEOUT   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       loadStart;
  logic       loadEnd;
  logic       cheatsLoaded;
  logic [7:0] cheatCount;
  logic       errorFlag;

  cheat_loader_if bif();

  cheat_loader #(
    .MAX_CHEATS(MAX_CHEATS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_load_start   (loadStart),
    .i_load_end     (loadEnd),
    .bus            (bif),
    .o_cheats_loaded(cheatsLoaded),
    .o_cheat_count  (cheatCount),
    .o_error        (errorFlag)
  );

  // free-running 100 MHz clock
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // list-level model
  int mCount;
  bit mError;
  bit mLoaded;

  task automatic checkOutput(input string tag, input logic [128:0] observed,
                             input logic [128:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [128:0] expectedWord(input int slot, input logic [7:0] flags,
                                               input logic [15:0] addr, input logic [7:0] cmp,
                                               input logic [7:0] rep);
    logic [128:0] w;
    w           = '0;
    w[111:104]  = 8'(slot);
    w[96]       = flags[0];
    w[79:64]    = addr;
    w[39:32]    = cmp;
    w[7:0]      = rep;
    return w;
  endfunction

  task automatic checkStatus(input string tag);
    checkOutput({tag, "Count"}, cheatCount, 129'(mCount));
    checkOutput({tag, "Error"}, errorFlag, 129'(mError));
    checkOutput({tag, "Loaded"}, cheatsLoaded, 129'(mLoaded));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Cyc"}, bif.o_wb_cyc, 0);
    checkOutput({tag, "Stb"}, bif.o_wb_stb, 0);
    checkOutput({tag, "We"}, bif.o_wb_we, 0);
    checkOutput({tag, "Addr"}, bif.o_wb_addr, 0);
    checkOutput({tag, "Data"}, bif.o_wb_odata, 0);
    checkOutput({tag, "Ready"}, bif.o_byte_ready, 0);
    checkOutput({tag, "Loaded"}, cheatsLoaded, 0);
    checkOutput({tag, "Count"}, cheatCount, 0);
    checkOutput({tag, "Error"}, errorFlag, 0);
  endtask

  task automatic sendByte(input logic [7:0] b);
    int guard;
    guard = 0;
    if ($urandom_range(0, 3) == 0) begin
      bif.i_byte_valid = 1'b0;
      tick();
    end
    bif.i_byte_valid = 1'b1;
    bif.i_byte       = b;
    while (bif.o_byte_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("byteReady", bif.o_byte_ready, 1);
    tick();
    bif.i_byte_valid = 1'b0;
  endtask

  task automatic startList(input bit withEnd);
    loadStart = 1'b1;
    loadEnd   = withEnd;
    tick();
    loadStart = 1'b0;
    loadEnd   = 1'b0;
    mCount  = 0;
    mError  = 1'b0;
    mLoaded = 1'b0;
    checkOutput("startReady", bif.o_byte_ready, 1);
    checkStatus("start");
  endtask

  task automatic endList(input bit partial);
    loadEnd = 1'b1;
    tick();
    loadEnd = 1'b0;
    if (partial) mError = 1'b1;
    mLoaded = 1'b1;
    checkOutput("endReady", bif.o_byte_ready, 0);
    checkStatus("end");
  endtask

  // One full record plus the slave's answer to the resulting write.
  task automatic applyStimulus(input logic [7:0] flags, input logic [15:0] addr,
                               input logic [7:0] cmp, input logic [7:0] rep,
                               input int resp, input int nStall, input int ackDelay,
                               input bit endDuring);
    logic [128:0] w;
    int           stbCycles;
    int           waitCycles;
    bit           expectWrite;
    expectWrite = (mCount < MAX_CHEATS);
    w = expectedWord(mCount + 1, flags, addr, cmp, rep);
    bif.i_wb_stall = 1'b0;
    bif.i_wb_ack   = 1'b0;
    bif.i_wb_err   = 1'b0;
    sendByte(flags);
    sendByte(addr[15:8]);
    sendByte(addr[7:0]);
    sendByte(cmp);
    sendByte(rep);
    if (!expectWrite) begin
      mError = 1'b1;
      checkOutput("discardNoCyc", bif.o_wb_cyc, 0);
      checkOutput("discardReady", bif.o_byte_ready, 1);
      checkStatus("discard");
      return;
    end
    checkOutput("wbCyc", bif.o_wb_cyc, 1);
    checkOutput("wbWe", bif.o_wb_we, 1);
    checkOutput("wbAddr", bif.o_wb_addr, 1);
    checkOutput("wbData", bif.o_wb_odata, w);
    checkOutput("readyLowInReq", bif.o_byte_ready, 0);
    stbCycles = (bif.o_wb_stb === 1'b1) ? 1 : 0;
    bif.i_wb_stall = 1'b1;
    for (int i = 0; i < nStall; i++) begin
      bif.i_wb_ack = 1'($urandom_range(0, 1));
      tick();
      if (bif.o_wb_stb === 1'b1) stbCycles++;
    end
    checkOutput("stallData", bif.o_wb_odata, w);
    checkOutput("stallAddr", bif.o_wb_addr, 1);
    bif.i_wb_stall = 1'b0;
    bif.i_wb_ack   = (resp == RESP_ACK_NOW);
    tick();
    bif.i_wb_ack = 1'b0;
    if (bif.o_wb_stb === 1'b1) stbCycles++;
    checkOutput("stbCycles", stbCycles, 129'(nStall + 1));
    case (resp)
      RESP_ACK_NOW: begin
        mCount++;
      end
      RESP_ACK_LATER, RESP_ERR: begin
        checkOutput("waitCyc", bif.o_wb_cyc, 1);
        for (int j = 0; j < ackDelay; j++) begin
          bif.i_wb_ack = (resp == RESP_ACK_LATER) && (j == ackDelay - 1);
          bif.i_wb_err = (resp == RESP_ERR) && (j == ackDelay - 1);
          loadEnd      = endDuring && (j == 0);
          tick();
        end
        bif.i_wb_ack = 1'b0;
        bif.i_wb_err = 1'b0;
        loadEnd      = 1'b0;
        if (resp == RESP_ACK_LATER) mCount++;
        else mError = 1'b1;
      end
      default: begin
        waitCycles = 0;
        while (bif.o_wb_cyc === 1'b1 && waitCycles < TIMEOUT + 20) begin
          waitCycles++;
          tick();
        end
        checkOutput("timeoutCycles", waitCycles, 129'(TIMEOUT));
        mError = 1'b1;
      end
    endcase
    checkOutput("cycDrop", bif.o_wb_cyc, 0);
    checkOutput("stbLow", bif.o_wb_stb, 0);
    if (endDuring) begin
      mLoaded = 1'b1;
      checkOutput("endPendReady", bif.o_byte_ready, 0);
    end else begin
      checkOutput("backToCollect", bif.o_byte_ready, 1);
    end
    checkStatus("afterWrite");
  endtask

  task automatic randomRecord(input bit allowEnd, output bit ended);
    int resp;
    int pick;
    bit endDuring;
    pick = $urandom_range(0, 7);
    if (pick < 3)       resp = RESP_ACK_NOW;
    else if (pick < 7)  resp = RESP_ACK_LATER;
    else                resp = RESP_ERR;
    endDuring = allowEnd && (mCount < MAX_CHEATS) && (resp == RESP_ACK_LATER)
                && ($urandom_range(0, 7) == 0);
    applyStimulus(8'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                  resp, $urandom_range(0, 3), $urandom_range(1, 4), endDuring);
    ended = endDuring;
  endtask

  // watchdog so a stuck design cannot hang the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    bit ended;
    int nrec;
    reset            = 1'b1;
    loadStart        = 1'b0;
    loadEnd          = 1'b0;
    bif.i_byte_valid = 1'b0;
    bif.i_byte       = '0;
    bif.i_wb_ack     = 1'b0;
    bif.i_wb_stall   = 1'b0;
    bif.i_wb_err     = 1'b0;
    mCount = 0; mError = 1'b0; mLoaded = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checkAllZero("reset");

    // list end while idle is ignored
    loadEnd = 1'b1;
    tick();
    loadEnd = 1'b0;
    checkStatus("idleEnd");

    // reference record, acknowledged together with the strobe
    startList(1'b0);
    applyStimulus(8'h01, 16'h23A2, 8'hD6, 8'h24, RESP_ACK_NOW, 0, 1, 1'b0);

    // three stalled cycles, then ack two cycles after acceptance
    startList(1'b0);
    applyStimulus(8'h00, 16'h1234, 8'h56, 8'h78, RESP_ACK_LATER, 3, 2, 1'b0);

    // bus error while waiting for ack, then the next record reuses slot 1
    startList(1'b0);
    applyStimulus(8'h01, 16'hBEEF, 8'h11, 8'h22, RESP_ERR, 0, 2, 1'b0);
    applyStimulus(8'h01, 16'hCAFE, 8'h33, 8'h44, RESP_ACK_NOW, 1, 1, 1'b0);

    // slave never answers
    startList(1'b0);
    applyStimulus(8'h00, 16'h0F0F, 8'h99, 8'hAA, RESP_TIMEOUT, 0, 1, 1'b0);

    // five records into four slots
    startList(1'b0);
    for (int r = 0; r < 5; r++) begin
      applyStimulus(8'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                    RESP_ACK_NOW, $urandom_range(0, 2), 1, 1'b0);
    end
    endList(1'b0);
    checkOutput("fullCount", cheatCount, 4);

    // list ends in the middle of the second record, then reset
    startList(1'b0);
    applyStimulus(8'h01, 16'h4000, 8'h01, 8'h02, RESP_ACK_NOW, 0, 1, 1'b0);
    sendByte(8'h00);
    sendByte(8'h12);
    sendByte(8'h34);
    endList(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mCount = 0; mError = 1'b0; mLoaded = 1'b0;
    checkAllZero("afterPartialReset");

    // reset while a strobe is stalled ends the bus cycle at once
    startList(1'b0);
    bif.i_wb_stall = 1'b1;
    sendByte(8'h01); sendByte(8'h55); sendByte(8'h66); sendByte(8'h77); sendByte(8'h88);
    checkOutput("stalledCyc", bif.o_wb_cyc, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkAllZero("midTxnReset");
    tick();
    tick();
    checkOutput("postResetCyc", bif.o_wb_cyc, 0);
    bif.i_wb_stall = 1'b0;

    // randomized lists
    for (int l = 0; l < 10; l++) begin
      startList($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        sendByte(8'($urandom));
        sendByte(8'($urandom));
        startList(1'b0);
      end
      nrec  = $urandom_range(0, 6);
      ended = 1'b0;
      for (int r = 0; r < nrec && !ended; r++) begin
        randomRecord(1'b1, ended);
      end
      if (!ended) begin
        if ($urandom_range(0, 2) == 0) begin
          for (int b = 0; b < $urandom_range(1, 4); b++) sendByte(8'($urandom));
          endList(1'b1);
        end else begin
          endList(1'b0);
        end
      end
      loadEnd = 1'b1;
      tick();
      loadEnd = 1'b0;
      checkOutput("doneEndReady", bif.o_byte_ready, 0);
      checkStatus("doneEnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
